// File: rtl/serial_sub_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl_pkg
//   Shared definitions for the bit-serial subtractor controller:
//   - state_e        : controller FSM states (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH  : default operand width in bits
// -----------------------------------------------------------------------------
package serial_sub_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_ctrl_fs.sv
// -----------------------------------------------------------------------------
// fs_cell
//   Combinational 1-bit full subtractor computing a - b - bi.
//   Ports:
//     a   in  minuend bit
//     b   in  subtrahend bit
//     bi  in  borrow in
//     d   out difference bit
//     bo  out borrow out
// -----------------------------------------------------------------------------
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  // Borrow when a=0,b=1, or when the bits are equal and a borrow arrives.
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
//   Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per clock,
//   LSB first, through a single fs_cell. Result is reported by a one-cycle done
//   pulse and held until the next accepted start.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     start  in   request; only honoured in IDLE
//     a, b   in   WIDTH-bit operands, captured on the accept edge
//     bin    in   initial borrow, captured on the accept edge
//     busy   out  state != IDLE
//     done   out  high for the single DONE cycle
//     diff   out  WIDTH-bit result
//     bout   out  final borrow (a < b + bin, unsigned)
//     zero   out  diff == 0 for the latest completed operation
// -----------------------------------------------------------------------------
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] diff_shift;

  fs_cell u_fs_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Result bits enter from the MSB side so that after WIDTH shifts bit 0 of
  // the result sits in diff[0].
  assign diff_shift = {cell_d, diff_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = cell_bo;
        diff_d = diff_shift;
        if (cnt_q == LAST) begin
          // Last bit: publish flags and park the counter so it never
          // runs past WIDTH-1.
          state_d = DONE;
          cnt_d   = '0;
          bout_d  = cell_bo;
          zero_d  = (diff_shift == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_sub_ctrl
//   Directed bench for serial_sub_ctrl (WIDTH = 8) followed by a run of
//   back-to-back operations with start held high and operands from $urandom.
// -----------------------------------------------------------------------------
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) at falling edges until done is high; n = falling edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] ed, input logic eb, input logic ez);
    check({tag, "_done"}, 32'(done), 32'h1);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
  endtask

  // One full operation: accept, scramble inputs, check latency, result and
  // that done lasts a single cycle.
  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input logic [7:0] ed, input logic eb, input logic ez);
    int n;
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv; bin = ~bi;
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'(W));
    check_res(tag, ed, eb, ez);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'h0);
    check({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin : stim
    int n;
    int cnt;
    int prev;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] r;

    // Reset state, with a request already waiting on start.
    rst_n = 1'b0; start = 1'b1; a = 8'h5A; b = 8'h3C; bin = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_diff", 32'(diff), 32'h0);
    check("rst_bout", 32'(bout), 32'h0);
    check("rst_zero", 32'(zero), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold", 32'(busy), 32'h0);

    // First rising edge after release with start=1 is the accept edge.
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_busy", 32'(busy), 32'h1);
    wait_done(n);
    check("first_lat", 32'(n), 32'(W));
    check_res("first", 8'h1E, 1'b0, 1'b0);
    @(negedge clk);
    check("first_pulse", 32'(done), 32'h0);

    do_op("underflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    do_op("equal",     8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1);
    do_op("borrowin",  8'h05, 8'h02, 1'b1, 8'h02, 1'b0, 1'b0);

    // Start pulsed three cycles into RUN must be dropped.
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    a = 8'h11; b = 8'h22; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ign_lat", 32'(n), 32'(W - 4));
    check_res("ign", 8'h1E, 1'b0, 1'b0);
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("ign_extra_done", 32'(cnt), 32'h0);

    // Leave zero=1 so the reset clear is visible on it too.
    do_op("pre_rst", 8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset in RUN cycle 4: partial diff 0xE0 must clear at once.
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_partial", 32'(diff), 32'hE0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'h0);
    check("mid_done", 32'(done), 32'h0);
    check("mid_diff", 32'(diff), 32'h0);
    check("mid_bout", 32'(bout), 32'h0);
    check("mid_zero", 32'(zero), 32'h0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) cnt++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("mid_no_done", 32'(cnt), 32'h0);
    check("mid_idle", 32'(busy), 32'h0);
    do_op("after_rst", 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0);

    // Back-to-back with start held high; operands change only while in DONE.
    @(negedge clk);
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
    a = ra; b = rb; bin = rc; start = 1'b1;
    prev = 0;
    for (int k = 0; k < 200; k++) begin
      r = {1'b0, ra} - {1'b0, rb} - {8'h00, rc};
      wait_done(n);
      check("b2b_done", 32'(done), 32'h1);
      if (k > 0) check("b2b_spacing", 32'(cyc - prev), 32'(W + 2));
      prev = cyc;
      check("b2b_diff", 32'(diff), 32'(r[7:0]));
      check("b2b_bout", 32'(bout), 32'(r[8]));
      check("b2b_zero", 32'(zero), 32'(r[7:0] == 8'h00));
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      if (k % 37 == 5) begin
        rb = ra; rc = 1'b0;
      end
      a = ra; b = rb; bin = rc;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("end_idle", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
